// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic operand feeder.
package systolic_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD_WET,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Default array geometry; BW_ACT_DEF is the width of one activation lane slice.
  localparam int unsigned ACCU_NUM_DEF  = 5;
  localparam int unsigned BN_NUM_DEF    = 10;
  localparam int unsigned BW_ACT_DEF    = 8;
  localparam int unsigned BW_WET_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned DRAIN_CYC_DEF = 16;

  // Cycles from accept to the last MAC-enabled cycle; done follows one cycle later.
  function automatic int unsigned tile_len(input int unsigned n, input int unsigned k,
                                           input int unsigned drain);
    return 3 + n + 2 * k + drain;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// SRAM read ports and PE-array operand ports of the feeder.
interface systolic_feeder_if #(
  parameter int unsigned ACCU_NUM = 5,
  parameter int unsigned BW_ACT   = 8,
  parameter int unsigned BW_WET   = 8,
  parameter int unsigned ADDR_W   = 8
);
  logic                       wet_rd_en;
  logic [ADDR_W-1:0]          wet_rd_addr;
  logic [BW_WET-1:0]          wet_rd_data;
  logic                       act_rd_en;
  logic [ADDR_W-1:0]          act_rd_addr;
  logic [ACCU_NUM*BW_ACT-1:0] act_rd_data;
  logic                       PE_clear_acc;
  logic                       PE_mac_enable;
  logic                       PE_weight_partial_sel;
  logic signed [BW_WET-1:0]   PE_wet_in;
  logic signed [BW_ACT-1:0]   PE_act_in [ACCU_NUM];

  modport master (
    output wet_rd_en, wet_rd_addr, act_rd_en, act_rd_addr,
    output PE_clear_acc, PE_mac_enable, PE_weight_partial_sel, PE_wet_in, PE_act_in,
    input  wet_rd_data, act_rd_data
  );

  modport slave (
    input  wet_rd_en, wet_rd_addr, act_rd_en, act_rd_addr,
    input  PE_clear_acc, PE_mac_enable, PE_weight_partial_sel, PE_wet_in, PE_act_in,
    output wet_rd_data, act_rd_data
  );
endinterface

// File: rtl/systolic_skew_lane.sv
// Valid-qualified delay line: DEPTH extra cycles after one capture stage, zero when invalid.
module systolic_skew_lane #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned BW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [BW-1:0] in_data,
  output logic [BW-1:0] out_data
);

  logic [DEPTH:0]         vld_q;
  logic [DEPTH:0][BW-1:0] dat_q;

  // Shift valid and data together; flush empties the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_data;
      for (int unsigned i = 1; i <= DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_data = vld_q[DEPTH] ? dat_q[DEPTH] : '0;

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer: clear, weight load, skewed activation stream, drain, done.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned ACCU_NUM  = ACCU_NUM_DEF,
  parameter int unsigned BN_NUM    = BN_NUM_DEF,
  parameter int unsigned BW_ACT    = BW_ACT_DEF,
  parameter int unsigned BW_WET    = BW_WET_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] wet_base,
  input  logic [ADDR_W-1:0] act_base,
  output logic              busy,
  output logic              done,
  systolic_feeder_if.master bus
);

  localparam int unsigned TILE_LEN     = tile_len(BN_NUM, ACCU_NUM, DRAIN_CYC);
  localparam int unsigned T_W          = $clog2(TILE_LEN + 2);
  localparam int unsigned T_LOAD_END   = 1 + ACCU_NUM;
  localparam int unsigned T_STREAM_END = 1 + ACCU_NUM + BN_NUM;
  localparam int unsigned T_MAC_START  = 4 + ACCU_NUM;

  state_t            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [ADDR_W-1:0] wet_base_q, act_base_q;
  logic              accept, flush;

  logic              busy_d, done_d, clr_d, mac_d, wen_d, aen_d;
  logic [ADDR_W-1:0] waddr_d, aaddr_d;

  logic              wet_vld_q, act_vld_q;
  logic [BW_ACT-1:0] lane_out [ACCU_NUM];

  assign accept = (state_q == ST_IDLE) && start && !abort;
  assign flush  = abort && (state_q != ST_IDLE);

  // State, tile-relative cycle counter and sampled base addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      wet_base_q <= '0;
      act_base_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (accept) begin
        wet_base_q <= wet_base;
        act_base_q <= act_base;
      end
    end
  end

  // Next state plus next-cycle values of every registered control output.
  // t counts cycles since accept, so all phase boundaries are plain compares on t.
  always_comb begin
    state_d = state_q;
    t_d     = t_q + T_W'(1);
    case (state_q)
      ST_IDLE: begin
        t_d = '0;
        if (accept) begin
          state_d = ST_CLEAR;
          t_d     = T_W'(1);
        end
      end
      ST_CLEAR:    state_d = ST_LOAD_WET;
      ST_LOAD_WET: if (t_q == T_W'(T_LOAD_END))   state_d = ST_STREAM;
      ST_STREAM:   if (t_q == T_W'(T_STREAM_END)) state_d = ST_DRAIN;
      ST_DRAIN:    if (t_q == T_W'(TILE_LEN))     state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      t_d     = '0;
    end

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    clr_d   = (state_d == ST_CLEAR);
    wen_d   = (state_d == ST_LOAD_WET);
    aen_d   = (state_d == ST_STREAM);
    mac_d   = ((state_d == ST_STREAM) || (state_d == ST_DRAIN)) && (t_d >= T_W'(T_MAC_START));
    waddr_d = '0;
    aaddr_d = '0;
    // Deepest PE's weight goes first, so the address walks downward from base+K-1.
    if (wen_d) waddr_d = wet_base_q + ADDR_W'(ACCU_NUM - 1) - ADDR_W'(t_d - T_W'(2));
    if (aen_d) aaddr_d = act_base_q + ADDR_W'(t_d - T_W'(2 + ACCU_NUM));
  end

  // Registered control outputs and read strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.PE_clear_acc  <= 1'b0;
      bus.PE_mac_enable <= 1'b0;
      bus.wet_rd_en     <= 1'b0;
      bus.wet_rd_addr   <= '0;
      bus.act_rd_en     <= 1'b0;
      bus.act_rd_addr   <= '0;
    end else begin
      busy              <= busy_d;
      done              <= done_d;
      bus.PE_clear_acc  <= clr_d;
      bus.PE_mac_enable <= mac_d;
      bus.wet_rd_en     <= wen_d;
      bus.wet_rd_addr   <= waddr_d;
      bus.act_rd_en     <= aen_d;
      bus.act_rd_addr   <= aaddr_d;
    end
  end

  // Read-data valid tracking and the registered weight stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wet_vld_q                 <= 1'b0;
      act_vld_q                 <= 1'b0;
      bus.PE_wet_in             <= '0;
      bus.PE_weight_partial_sel <= 1'b0;
    end else if (flush) begin
      wet_vld_q                 <= 1'b0;
      act_vld_q                 <= 1'b0;
      bus.PE_wet_in             <= '0;
      bus.PE_weight_partial_sel <= 1'b0;
    end else begin
      wet_vld_q                 <= bus.wet_rd_en;
      act_vld_q                 <= bus.act_rd_en;
      bus.PE_wet_in             <= wet_vld_q ? bus.wet_rd_data : '0;
      bus.PE_weight_partial_sel <= wet_vld_q;
    end
  end

  for (genvar k = 0; k < ACCU_NUM; k++) begin : g_lane
    systolic_skew_lane #(
      .DEPTH (k),
      .BW    (BW_ACT)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .in_vld   (act_vld_q),
      .in_data  (bus.act_rd_data[k*BW_ACT +: BW_ACT]),
      .out_data (lane_out[k])
    );
    assign bus.PE_act_in[k] = lane_out[k];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: small tile (K=2,N=3,DRAIN=2) and a default-size tile with random data.
module tb_systolic_feeder;

  logic       clk;
  logic       reset_n;
  logic       start_s, abort_s, start_d, abort_d;
  logic [7:0] wb_s, ab_s, wb_d, ab_d;
  logic       busy_s, done_s, busy_d, done_d;

  logic [7:0] wmem [256];
  logic [7:0] amem [256][5];

  int checks = 0;
  int errors = 0;

  systolic_feeder_if #(.ACCU_NUM(2), .BW_ACT(8), .BW_WET(8), .ADDR_W(8)) bs ();
  systolic_feeder_if #(.ACCU_NUM(5), .BW_ACT(8), .BW_WET(8), .ADDR_W(8)) bd ();

  systolic_feeder #(
    .ACCU_NUM(2), .BN_NUM(3), .BW_ACT(8), .BW_WET(8), .ADDR_W(8), .DRAIN_CYC(2)
  ) u_s (
    .clk(clk), .reset_n(reset_n), .start(start_s), .abort(abort_s),
    .wet_base(wb_s), .act_base(ab_s), .busy(busy_s), .done(done_s), .bus(bs)
  );

  systolic_feeder #(
    .ACCU_NUM(5), .BN_NUM(10), .BW_ACT(8), .BW_WET(8), .ADDR_W(8), .DRAIN_CYC(16)
  ) u_d (
    .clk(clk), .reset_n(reset_n), .start(start_d), .abort(abort_d),
    .wet_base(wb_d), .act_base(ab_d), .busy(busy_d), .done(done_d), .bus(bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bs.wet_rd_en) bs.wet_rd_data <= wmem[bs.wet_rd_addr];
    if (bs.act_rd_en) for (int k = 0; k < 2; k++) bs.act_rd_data[k*8 +: 8] <= amem[bs.act_rd_addr][k];
    if (bd.wet_rd_en) bd.wet_rd_data <= wmem[bd.wet_rd_addr];
    if (bd.act_rd_en) for (int k = 0; k < 5; k++) bd.act_rd_data[k*8 +: 8] <= amem[bd.act_rd_addr][k];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int t, input string what,
                     input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d %s observed %0d expected %0d", tag, t, what, obs, exp);
    end
  endtask

  // Compare every output against the timing formulas for tile offset t (t=0 means idle).
  task automatic check_t(input string tag, input bit d, input int t,
                         input logic [7:0] wb, input logic [7:0] ab);
    int K, N, D, T, n;
    logic o_busy, o_done, o_clr, o_mac, o_sel, o_wen, o_aen;
    logic [7:0] o_waddr, o_aaddr, ea;
    logic signed [7:0] o_win;
    logic signed [7:0] o_act [5];
    logic signed [63:0] e;
    K = d ? 5 : 2;
    N = d ? 10 : 3;
    D = d ? 16 : 2;
    T = 3 + N + 2 * K + D;
    for (int k = 0; k < 5; k++) o_act[k] = '0;
    if (d) begin
      o_busy = busy_d; o_done = done_d; o_clr = bd.PE_clear_acc; o_mac = bd.PE_mac_enable;
      o_sel = bd.PE_weight_partial_sel; o_wen = bd.wet_rd_en; o_aen = bd.act_rd_en;
      o_waddr = bd.wet_rd_addr; o_aaddr = bd.act_rd_addr; o_win = bd.PE_wet_in;
      for (int k = 0; k < 5; k++) o_act[k] = bd.PE_act_in[k];
    end else begin
      o_busy = busy_s; o_done = done_s; o_clr = bs.PE_clear_acc; o_mac = bs.PE_mac_enable;
      o_sel = bs.PE_weight_partial_sel; o_wen = bs.wet_rd_en; o_aen = bs.act_rd_en;
      o_waddr = bs.wet_rd_addr; o_aaddr = bs.act_rd_addr; o_win = bs.PE_wet_in;
      o_act[0] = bs.PE_act_in[0];
      o_act[1] = bs.PE_act_in[1];
    end
    chk(tag, t, "busy", o_busy, (t >= 1 && t <= T + 1));
    chk(tag, t, "done", o_done, (t == T + 1));
    chk(tag, t, "clear_acc", o_clr, (t == 1));
    chk(tag, t, "mac_enable", o_mac, (t >= 4 + K && t <= T));
    chk(tag, t, "wet_rd_en", o_wen, (t >= 2 && t <= 1 + K));
    ea = (t >= 2 && t <= 1 + K) ? 8'(int'(wb) + K - 1 - (t - 2)) : 8'h00;
    chk(tag, t, "wet_rd_addr", o_waddr, ea);
    chk(tag, t, "act_rd_en", o_aen, (t >= 2 + K && t <= 1 + K + N));
    ea = (t >= 2 + K && t <= 1 + K + N) ? 8'(int'(ab) + t - 2 - K) : 8'h00;
    chk(tag, t, "act_rd_addr", o_aaddr, ea);
    chk(tag, t, "weight_sel", o_sel, (t >= 4 && t <= 3 + K));
    e = '0;
    if (t >= 4 && t <= 3 + K) e = $signed(wmem[8'(int'(wb) + K - 1 - (t - 4))]);
    chk(tag, t, "wet_in", o_win, e);
    for (int k = 0; k < K; k++) begin
      n = t - 4 - K - k;
      e = '0;
      if (n >= 0 && n < N) e = $signed(amem[8'(int'(ab) + n)][k]);
      chk(tag, t, $sformatf("act_lane%0d", k), o_act[k], e);
    end
  endtask

  // Present start on the small DUT for one cycle; returns at tile offset 1.
  task automatic start_small(input logic [7:0] wb, input logic [7:0] ab, input bit hold);
    wb_s = wb; ab_s = ab; start_s = 1'b1;
    step();
    if (!hold) start_s = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    start_s = 0; abort_s = 0; start_d = 0; abort_d = 0;
    wb_s = '0; ab_s = '0; wb_d = '0; ab_d = '0;
    for (int a = 0; a < 256; a++) begin
      wmem[a] = '0;
      for (int k = 0; k < 5; k++) amem[a][k] = '0;
    end
    #2 reset_n = 1'b0;
    step(); step();
    check_t("reset", 0, 0, 8'h00, 8'h00);
    check_t("reset", 1, 0, 8'h00, 8'h00);
    reset_n = 1'b1;
    step();

    // Basic tile.
    wmem[8'h10] = 8'd3;  wmem[8'h11] = 8'hFC;
    amem[8'h20][0] = 8'd1;  amem[8'h20][1] = 8'd2;
    amem[8'h21][0] = 8'd5;  amem[8'h21][1] = 8'd6;
    amem[8'h22][0] = 8'hF9; amem[8'h22][1] = 8'd8;
    start_small(8'h10, 8'h20, 1'b0);
    for (int t = 1; t <= 16; t++) begin
      check_t("basic", 0, t, 8'h10, 8'h20);
      if (t == 4)  chk("basic", t, "hand_wet", bs.PE_wet_in, -4);
      if (t == 5)  chk("basic", t, "hand_wet", bs.PE_wet_in, 3);
      if (t == 6)  chk("basic", t, "hand_lane0", bs.PE_act_in[0], 1);
      if (t == 8)  chk("basic", t, "hand_lane0", bs.PE_act_in[0], -7);
      if (t == 9)  chk("basic", t, "hand_lane1", bs.PE_act_in[1], 8);
      if (t == 13) chk("basic", t, "hand_done", done_s, 1);
      step();
    end

    // Start held high for the whole tile: one tile, next accepted at done+1.
    start_small(8'h10, 8'h20, 1'b1);
    for (int t = 1; t <= 14; t++) begin
      check_t("hold", 0, t, 8'h10, 8'h20);
      step();
    end
    start_s = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      check_t("hold2", 0, t, 8'h10, 8'h20);
      step();
    end

    // Address wrap on both SRAM ports.
    wmem[8'h00] = 8'h25; wmem[8'hFF] = 8'h81;
    amem[8'hFE][0] = 8'h7F; amem[8'hFE][1] = 8'h80;
    amem[8'hFF][0] = 8'h11; amem[8'hFF][1] = 8'h22;
    amem[8'h00][0] = 8'h33; amem[8'h00][1] = 8'h44;
    start_small(8'hFF, 8'hFE, 1'b0);
    for (int t = 1; t <= 15; t++) begin
      check_t("wrap", 0, t, 8'hFF, 8'hFE);
      if (t == 2) chk("wrap", t, "hand_waddr", bs.wet_rd_addr, 8'h00);
      if (t == 3) chk("wrap", t, "hand_waddr", bs.wet_rd_addr, 8'hFF);
      if (t == 4) chk("wrap", t, "hand_aaddr", bs.act_rd_addr, 8'hFE);
      if (t == 5) chk("wrap", t, "hand_aaddr", bs.act_rd_addr, 8'hFF);
      if (t == 6) chk("wrap", t, "hand_aaddr", bs.act_rd_addr, 8'h00);
      step();
    end

    // Abort during STREAM at offset 6.
    start_small(8'h10, 8'h20, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      check_t("abort_pre", 0, t, 8'h10, 8'h20);
      if (t == 6) abort_s = 1'b1;
      step();
    end
    abort_s = 1'b0;
    for (int t = 7; t <= 16; t++) begin
      check_t("abort_idle", 0, 0, 8'h10, 8'h20);
      step();
    end
    start_small(8'h10, 8'h20, 1'b0);
    for (int t = 1; t <= 15; t++) begin
      check_t("abort_after", 0, t, 8'h10, 8'h20);
      step();
    end

    // Asynchronous reset in the middle of LOAD_WET.
    start_small(8'h10, 8'h20, 1'b0);
    check_t("rst_pre", 0, 1, 8'h10, 8'h20);
    step();
    check_t("rst_pre", 0, 2, 8'h10, 8'h20);
    reset_n = 1'b0;
    #1;
    check_t("rst_mid", 0, 0, 8'h10, 8'h20);
    step();
    reset_n = 1'b1;
    check_t("rst_held", 0, 0, 8'h10, 8'h20);
    step();
    start_small(8'h10, 8'h20, 1'b0);
    for (int t = 1; t <= 15; t++) begin
      check_t("rst_after", 0, t, 8'h10, 8'h20);
      step();
    end

    // Default geometry with random operands.
    for (int a = 8'h40; a < 8'h45; a++) wmem[a] = 8'($urandom);
    for (int a = 8'h80; a < 8'h8A; a++)
      for (int k = 0; k < 5; k++) amem[a][k] = 8'($urandom);
    wb_d = 8'h40; ab_d = 8'h80; start_d = 1'b1;
    step();
    start_d = 1'b0;
    for (int t = 1; t <= 42; t++) begin
      check_t("dflt", 1, t, 8'h40, 8'h80);
      if (t == 40) chk("dflt", t, "hand_done", done_d, 1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand sequencer for the 1xN weight-stationary systolic array. On `start` it does the following in order:
- clears the array accumulators;
- reads K weights from weight SRAM and streams them into the PE column;
- reads N activation rows from activation SRAM and presents them diagonally skewed, one lane per PE;
- holds MAC enable through a drain window, then pulses `done`.

It sits between the tile SRAMs and the array's operand ports.

## Interface
Parameters:
- ACCU_NUM, 5, K: PE column depth / activations per row
- BN_NUM, 10, N: activation rows (outputs) per tile
- BW_ACT, 8, activation width
- BW_WET, 8, weight width
- ADDR_W, 8, SRAM address width
- DRAIN_CYC, 16, MAC-enabled cycles after the last operand before `done`

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  tile request; accepted only in IDLE
- abort  in  1  synchronous cancel
- wet_base  in  ADDR_W  first weight address, sampled at accept
- act_base  in  ADDR_W  first activation-row address, sampled at accept
- busy  out  1  high from accept+1 until the `done` cycle inclusive
- done  out  1  one-cycle completion pulse
- wet_rd_en  out  1  weight read strobe
- wet_rd_addr  out  ADDR_W  weight address
- wet_rd_data  in  BW_WET  weight data, valid 1 cycle after strobe
- act_rd_en  out  1  activation read strobe
- act_rd_addr  out  ADDR_W  row address
- act_rd_data  in  ACCU_NUM*BW_ACT  row data, lane k at bits [k*BW_ACT +: BW_ACT], valid 1 cycle after strobe
- PE_clear_acc  out  1  accumulator clear to array
- PE_mac_enable  out  1  MAC enable to array
- PE_weight_partial_sel  out  1  1 = weight-load cycle
- PE_wet_in  out  signed BW_WET  weight stream
- PE_act_in  out  signed BW_ACT [ACCU_NUM]  skewed activation lanes

## Operation
- FSM states: IDLE, CLEAR, LOAD_WET, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 latches the bases and moves to CLEAR.
  - start while not in IDLE is ignored; it is not queued.
- CLEAR (1 cycle): PE_clear_acc=1.
- LOAD_WET (K cycles): read j issues to address wet_base+(K-1-j). The deepest PE's weight is sent first.
- STREAM (N cycles): read n issues to address act_base+n.
- DRAIN: runs until the last skewed lane value has been presented, plus DRAIN_CYC cycles.
- DONE (1 cycle): done=1, then IDLE.
- Skew: lane k delays its row data by k extra cycles. A lane with no valid row in a cycle outputs 0.
- Address arithmetic wraps modulo 2^ADDR_W.
- abort=1 in any non-IDLE state has these effects:
  - next cycle is IDLE;
  - all strobes and array controls drop;
  - skew pipelines and the PE_wet_in/PE_act_in registers are zeroed;
  - no `done` is issued.
- abort in IDLE has no effect. abort has priority over start in the same cycle.
- Asynchronous reset behaves like abort, applied immediately.
- Reset values: every output is 0, and the FSM is in IDLE.

## Timing
- Accept cycle s (IDLE, start=1). All array-facing outputs are registered.
- s+1: PE_clear_acc=1, busy=1.
- s+2 .. s+1+K: wet_rd_en=1.
- s+4+j (j=0..K-1): PE_wet_in = weight at wet_base+K-1-j, PE_weight_partial_sel=1. In all other cycles PE_wet_in=0 and sel=0.
- s+2+K .. s+1+K+N: act_rd_en=1, row n read at s+2+K+n.
- s+4+K+n+k: PE_act_in[k] = row n lane k.
- PE_mac_enable=1 from s+4+K through s+3+N+2K+DRAIN_CYC.
- done pulses at s+4+N+2K+DRAIN_CYC. The next start is accepted at done+1 at the earliest.
- Read strobes never overlap; at most one SRAM read per cycle per port.

## Structure
- Package systolic_feeder_pkg:
  - state enum;
  - lane-slice helper constant BW_ACT;
  - localparam for total tile length (3+N+2K+DRAIN_CYC).
- Sub-module systolic_skew_lane:
  - parameters DEPTH, BW;
  - valid-qualified delay line with zero-fill and synchronous flush for abort;
  - instantiated ACCU_NUM times with DEPTH=k.

## Test plan
- Basic tile, K=2 N=3 DRAIN_CYC=2, wet_base=0x10 (weights 3,-4), act_base=0x20 (rows {1,2},{5,6},{-7,8}), start at s:
  - clear at s+1;
  - PE_wet_in = -4 at s+4, 3 at s+5;
  - lane0 = 1,5,-7 at s+6..s+8;
  - lane1 = 2,6,8 at s+7..s+9;
  - done at s+13.
- Address wrap: act_base=0xFE, N=3 → reads at 0xFE, 0xFF, 0x00.
- start pulsed every cycle during busy → exactly one tile; the next is accepted at done+1.
- abort during STREAM at s+6 → at s+7 the state is IDLE, every output is 0, and no done is issued; a fresh start completes normally.
- Reset asserted mid-LOAD_WET → every output is 0 immediately; after release, start runs a full tile with correct timing.
- Defaults K=5 N=10 with random data → a scoreboard checks every lane, row, and cycle against the skew formula, and done at s+40.
